// File: rtl/score_bcd_scheduler.sv
// Two-channel score-to-BCD scheduler sharing one shift-per-clock double-dabble engine.
// Optional feature: define SCORE_BCD_ZERO_BLANK_EN to blank leading zeros with 4'hF.
module score_bcd_scheduler #(
  parameter int WIDTH   = 10,
  parameter int MAX_VAL = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_0,
  input  logic [WIDTH-1:0] bin_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] bin_1,
  output logic             ack_0,
  output logic             ack_1,
  output logic             done_0,
  output logic             done_1,
  output logic [3:0]       ch0_d2,
  output logic [3:0]       ch0_d1,
  output logic [3:0]       ch0_d0,
  output logic [3:0]       ch1_d2,
  output logic [3:0]       ch1_d1,
  output logic [3:0]       ch1_d0,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WRITE} state_e;

  localparam logic [WIDTH-1:0] MAX_BIN  = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LAST_CNT = 4'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [11:0]      ch0_q, ch0_d, ch1_q, ch1_d;

  logic             win_ch;
  logic [WIDTH-1:0] bin_sel;

  // Pre-shift correction: any nibble >= 5 would overflow past 9 once doubled.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [11:0] fmt_digits(input logic [11:0] b);
`ifdef SCORE_BCD_ZERO_BLANK_EN
    logic [11:0] r;
    r = b;
    if (b[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (b[7:4] == 4'd0) r[7:4] = 4'hF;
    end
    return r;
`else
    return b;
`endif
  endfunction

  // Tie goes to the channel not served last; a lone requester always wins.
  assign win_ch  = (req_0 && req_1) ? ~last_grant_q : req_1;
  assign bin_sel = win_ch ? bin_1 : bin_0;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    shreg_d      = shreg_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    ch0_d        = ch0_q;
    ch1_d        = ch1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_0 || req_1) begin
          gnt_d        = win_ch;
          last_grant_d = win_ch;
          shreg_d      = (bin_sel > MAX_BIN) ? MAX_BIN : bin_sel;
          bcd_d        = 12'd0;
          cnt_d        = 4'd0;
          ack0_d       = ~win_ch;
          ack1_d       = win_ch;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, shreg_d} = {dabble_adj(bcd_q), shreg_q} << 1;
        cnt_d            = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (gnt_q) begin
          ch1_d   = fmt_digits(bcd_q);
          done1_d = 1'b1;
        end else begin
          ch0_d   = fmt_digits(bcd_q);
          done0_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      shreg_q      <= '0;
      bcd_q        <= 12'd0;
      cnt_q        <= 4'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      ch0_q        <= 12'd0;
      ch1_q        <= 12'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      shreg_q      <= shreg_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      ch0_q        <= ch0_d;
      ch1_q        <= ch1_d;
    end
  end

  assign ack_0  = ack0_q;
  assign ack_1  = ack1_q;
  assign done_0 = done0_q;
  assign done_1 = done1_q;
  assign {ch0_d2, ch0_d1, ch0_d0} = ch0_q;
  assign {ch1_d2, ch1_d1, ch1_d0} = ch1_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
